// File: rtl/mod_inv_kaliski.sv
// Modular inverter: binary almost-inverse loop, correction, then per-mode halve/double fixup; one op in flight.
// Latency ~k+cnt+2 cycles (worst ~4*WIDTH+3); o_ready low while busy and a start during that time is dropped.
module mod_inv_kaliski #(
  parameter int WIDTH = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_m,
  output logic             o_ready,
  output logic             o_valid,
  output logic             o_err,
  output logic [WIDTH-1:0] o_result
);

  localparam int CNT_W = $clog2(2*WIDTH+1);
  localparam int RW    = WIDTH + 2;

  typedef enum logic [2:0] {IDLE, PH1, CORR, PH2, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [RW-1:0]    u;
  logic [RW-1:0]    v;
  logic [RW-1:0]    r;
  logic [RW-1:0]    s;
  logic [RW-1:0]    m;
  logic             mode;
  logic             err;
  logic [CNT_W-1:0] k;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] res;

  logic [RW-1:0]    x_ext;
  logic [RW-1:0]    m_in;
  logic             x_bad;
  logic [RW-1:0]    r_red;
  logic [RW-1:0]    r_corr;
  logic [RW-1:0]    r_sum;
  logic [RW-1:0]    r_half;
  logic [RW-1:0]    r_twice;
  logic [RW-1:0]    r_dbl;
  logic [CNT_W-1:0] cnt_init;
  logic [WIDTH-1:0] res_now;

  always_comb begin
    x_ext    = {2'b00, i_x};
    m_in     = {2'b00, i_m};
    x_bad    = (x_ext >= m_in);
    r_red    = (r >= m) ? (r - m) : r;
    r_corr   = m - r_red;
    r_sum    = r + m;
    r_half   = r[0] ? (r_sum >> 1) : (r >> 1);
    r_twice  = r << 1;
    r_dbl    = (r_twice >= m) ? (r_twice - m) : r_twice;
    // Montgomery output needs 2^(2W) overall, so top up whatever k the loop produced.
    cnt_init = mode ? (CNT_W'(2*WIDTH) - k) : k;
    res_now  = err ? '0 : r[WIDTH-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (i_start) state_nxt = x_bad ? DONE : PH1;
      PH1:  if (v == '0) state_nxt = (u != RW'(1)) ? DONE : CORR;
      CORR: state_nxt = (cnt_init == '0) ? DONE : PH2;
      PH2:  if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_ready  = (state == IDLE);
    o_valid  = (state == DONE);
    o_err    = (state == DONE) && err;
    o_result = (state == DONE) ? res_now : res;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      u    <= '0;
      v    <= '0;
      r    <= '0;
      s    <= '0;
      m    <= '0;
      mode <= 1'b0;
      err  <= 1'b0;
      k    <= '0;
      cnt  <= '0;
      res  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_start) begin
            m    <= m_in;
            mode <= i_mode;
            u    <= m_in;
            v    <= x_ext;
            r    <= '0;
            s    <= RW'(1);
            k    <= '0;
            err  <= x_bad;
          end
        end
        PH1: begin
          if (v != '0) begin
            if (!u[0]) begin
              u <= u >> 1;
              s <= s << 1;
            end else if (!v[0]) begin
              v <= v >> 1;
              r <= r << 1;
            end else if (u > v) begin
              u <= (u - v) >> 1;
              r <= r + s;
              s <= s << 1;
            end else begin
              v <= (v - u) >> 1;
              s <= s + r;
              r <= r << 1;
            end
            k <= k + CNT_W'(1);
          end else if (u != RW'(1)) begin
            // u ends as gcd(x, M); anything but 1 means no inverse exists.
            err <= 1'b1;
          end
        end
        CORR: begin
          r   <= r_corr;
          cnt <= cnt_init;
        end
        PH2: begin
          r   <= mode ? r_dbl : r_half;
          cnt <= cnt - CNT_W'(1);
        end
        DONE: res <= res_now;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_inv_kaliski.sv
// Bench for mod_inv_kaliski: an 8-bit instance checked against brute-force inverses, a 255-bit instance
// checked by multiplying the result back modulo M.
module tb_mod_inv_kaliski;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       s8 = 1'b0;
  logic       md8 = 1'b0;
  logic [7:0] x8 = '0;
  logic [7:0] mm8 = 8'd13;
  logic       rdy8;
  logic       vld8;
  logic       err8;
  logic [7:0] res8;

  logic         sb = 1'b0;
  logic         mdb = 1'b0;
  logic [254:0] xb = '0;
  logic [254:0] mb = '0;
  logic         rdyb;
  logic         vldb;
  logic         errb;
  logic [254:0] resb;

  int errors = 0;
  int checks = 0;

  mod_inv_kaliski #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(s8), .i_mode(md8), .i_x(x8), .i_m(mm8),
    .o_ready(rdy8), .o_valid(vld8), .o_err(err8), .o_result(res8)
  );

  mod_inv_kaliski #(.WIDTH(255)) dutw (
    .i_clk(clk), .i_rst(rst), .i_start(sb), .i_mode(mdb), .i_x(xb), .i_m(mb),
    .o_ready(rdyb), .o_valid(vldb), .o_err(errb), .o_result(resb)
  );

  // Reference: search for y with x*y == 1 mod m; Montgomery mode scales by 2^16 mod m.
  task automatic model8(input logic md, input logic [7:0] x, input logic [7:0] m,
                        output logic [7:0] y, output logic e);
    int xi;
    int mi;
    xi = int'(x);
    mi = int'(m);
    y = '0;
    e = 1'b1;
    if (xi < mi) begin
      for (int c = 1; c < mi; c++) begin
        if ((xi * c) % mi == 1) begin
          e = 1'b0;
          y = md ? 8'((c * 65536) % mi) : 8'(c);
        end
      end
    end
  endtask

  task automatic op8(input logic md, input logic [7:0] x, input logic [7:0] m,
                     output logic [7:0] res, output logic e, output int lat, output int nvld);
    int t;
    res = '0; e = 1'b0; lat = 0; nvld = 0; t = 0;
    while (!rdy8 && t < 500) begin @(posedge clk); #1; t++; end
    md8 = md; x8 = x; mm8 = m; s8 = 1'b1;
    @(posedge clk); #1;
    s8 = 1'b0;
    while (!vld8 && lat < 200) begin @(posedge clk); #1; lat++; end
    if (vld8) begin
      nvld = 1; res = res8; e = err8;
      @(posedge clk); #1;
      if (vld8) nvld++;
    end
  endtask

  task automatic opw(input logic md, input logic [254:0] x, input logic [254:0] m,
                     output logic [254:0] res, output logic e, output int lat, output int nvld);
    int t;
    res = '0; e = 1'b0; lat = 0; nvld = 0; t = 0;
    while (!rdyb && t < 500) begin @(posedge clk); #1; t++; end
    mdb = md; xb = x; mb = m; sb = 1'b1;
    @(posedge clk); #1;
    sb = 1'b0;
    while (!vldb && lat < 1100) begin @(posedge clk); #1; lat++; end
    if (vldb) begin
      nvld = 1; res = resb; e = errb;
      @(posedge clk); #1;
      if (vldb) nvld++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rdy8 !== 1'b1) begin errors++; $display("FAIL reset_ready8: got %b expected 1", rdy8); end
    checks++; if (vld8 !== 1'b0) begin errors++; $display("FAIL reset_valid8: got %b expected 0", vld8); end
    checks++; if (err8 !== 1'b0) begin errors++; $display("FAIL reset_err8: got %b expected 0", err8); end
    checks++; if (res8 !== 8'd0) begin errors++; $display("FAIL reset_result8: got %0d expected 0", res8); end
    checks++; if (rdyb !== 1'b1) begin errors++; $display("FAIL reset_readyw: got %b expected 1", rdyb); end
    checks++; if (resb !== '0) begin errors++; $display("FAIL reset_resultw: got %h expected 0", resb); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [7:0] cm [5];
    logic [7:0] cx [5];
    logic       cmd [5];
    logic [7:0] cr [5];
    logic       ce [5];
    logic [7:0] res;
    logic       e;
    int         lat;
    int         nv;
    cm = '{8'd13, 8'd13, 8'd15, 8'd13, 8'd13};
    cx = '{8'd3, 8'd1, 8'd6, 8'd0, 8'd13};
    cmd = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    cr = '{8'd9, 8'd3, 8'd0, 8'd0, 8'd0};
    ce = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      op8(cmd[i], cx[i], cm[i], res, e, lat, nv);
      checks++; if (nv !== 1) begin errors++; $display("FAIL dir%0d_pulses: got %0d expected 1", i, nv); end
      checks++; if (res !== cr[i]) begin errors++; $display("FAIL dir%0d_result: got %0d expected %0d", i, res, cr[i]); end
      checks++; if (e !== ce[i]) begin errors++; $display("FAIL dir%0d_err: got %b expected %b", i, e, ce[i]); end
    end
  endtask

  task automatic test_random8();
    logic [7:0] m;
    logic [7:0] x;
    logic       md;
    logic [7:0] res;
    logic [7:0] y;
    logic       e;
    logic       ee;
    int         lat;
    int         nv;
    for (int i = 0; i < 60; i++) begin
      m  = 8'($urandom_range(1, 127) * 2 + 1);
      x  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, int'(m) - 1));
      md = 1'($urandom_range(0, 1));
      model8(md, x, m, y, ee);
      op8(md, x, m, res, e, lat, nv);
      checks++; if (nv !== 1) begin errors++; $display("FAIL rnd%0d_pulses: got %0d expected 1", i, nv); end
      checks++; if (res !== y || e !== ee) begin errors++; $display("FAIL rnd%0d_value: got %0d/%b expected %0d/%b (x=%0d m=%0d mode=%b)", i, res, e, y, ee, x, m, md); end
      checks++; if (lat > 4*8+3) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected <= 35", i, lat); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] res;
    logic       e;
    int         lat;
    int         nv;
    op8(1'b0, 8'd2, 8'd11, res, e, lat, nv);
    checks++; if (rdy8 !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", rdy8); end
    checks++; if (res !== 8'd6 || nv !== 1) begin errors++; $display("FAIL b2b_first: got %0d expected 6", res); end
    op8(1'b0, 8'd7, 8'd11, res, e, lat, nv);
    checks++; if (res !== 8'd8 || e !== 1'b0 || nv !== 1) begin errors++; $display("FAIL b2b_second: got %0d expected 8", res); end
  endtask

  task automatic test_busy();
    int t;
    int extra;
    t = 0;
    extra = 0;
    while (!rdy8 && t < 500) begin @(posedge clk); #1; t++; end
    md8 = 1'b0; x8 = 8'd3; mm8 = 8'd13; s8 = 1'b1;
    @(posedge clk); #1;
    x8 = 8'd5; md8 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (rdy8 !== 1'b0) begin errors++; $display("FAIL busy_ready%0d: got %b expected 0", i, rdy8); end
      @(posedge clk); #1;
    end
    s8 = 1'b0;
    t = 0;
    while (!vld8 && t < 200) begin @(posedge clk); #1; t++; end
    checks++; if (vld8 !== 1'b1 || res8 !== 8'd9) begin errors++; $display("FAIL busy_result: got %b/%0d expected 1/9", vld8, res8); end
    for (int i = 0; i < 15; i++) begin @(posedge clk); #1; if (vld8) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL busy_extra_valid: got %0d expected 0", extra); end
    checks++; if (res8 !== 8'd9) begin errors++; $display("FAIL busy_hold: got %0d expected 9", res8); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] res;
    logic       e;
    int         lat;
    int         nv;
    int         seen;
    md8 = 1'b0; x8 = 8'd3; mm8 = 8'd13; s8 = 1'b1;
    @(posedge clk); #1;
    s8 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (rdy8 !== 1'b1 || vld8 !== 1'b0 || res8 !== 8'd0) begin errors++; $display("FAIL midrst_state: got rdy=%b vld=%b res=%0d expected 1/0/0", rdy8, vld8, res8); end
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; if (vld8) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_novalid: got %0d expected 0", seen); end
    op8(1'b1, 8'd1, 8'd13, res, e, lat, nv);
    checks++; if (res !== 8'd3 || e !== 1'b0 || nv !== 1) begin errors++; $display("FAIL midrst_after: got %0d/%b expected 3/0", res, e); end
  endtask

  task automatic test_wide();
    logic [254:0] m;
    logic [254:0] x;
    logic [254:0] res;
    logic [254:0] rx;
    logic [511:0] one;
    logic [511:0] r2;
    logic [511:0] prod;
    logic [511:0] want;
    logic         e;
    logic         md;
    int           lat;
    int           nv;
    m = '1;
    m = m - 255'd18;
    one = 512'd1;
    r2 = (one << 510) % {257'd0, m};
    opw(1'b0, 255'd2, m, res, e, lat, nv);
    checks++; if (res !== (m >> 1) + 255'd1 || e !== 1'b0 || nv !== 1) begin errors++; $display("FAIL wide_two: got %h expected %h", res, (m >> 1) + 255'd1); end
    for (int i = 0; i < 6; i++) begin
      rx = '0;
      for (int j = 0; j < 8; j++) rx = {rx[222:0], 32'($urandom)};
      x = rx % m;
      if (x == '0) x = 255'd1;
      md = 1'(i % 2);
      opw(md, x, m, res, e, lat, nv);
      prod = ({257'd0, x} * {257'd0, res}) % {257'd0, m};
      want = md ? r2 : 512'd1;
      checks++; if (prod !== want || e !== 1'b0 || nv !== 1) begin errors++; $display("FAIL wide_rnd%0d: x*out mod M = %h expected %h (err=%b)", i, prod, want, e); end
      checks++; if (res >= m) begin errors++; $display("FAIL wide_range%0d: got %h expected < M", i, res); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random8();
    test_back_to_back();
    test_busy();
    test_reset_mid();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
